// File: rtl/if_prefetch_stage.sv
// Instruction-fetch prefetch stage: issues word-aligned fetch requests,
// tracks in-flight requests and their PCs, buffers returned instructions,
// and flushes / discards stale responses on a redirect.

// Protocol and occupancy invariants of the prefetch stage.
module if_prefetch_stage_chk #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = 3
) (
  input logic          clk,
  input logic          rst_n,
  input logic          redirect_i,
  input logic          mem_req_o,
  input logic          mem_gnt_i,
  input logic          mem_rvalid_i,
  input logic [1:0]    mem_addr_lo,
  input logic [CW-1:0] count,
  input logic [CW-1:0] outstanding
);
  localparam logic [CW:0] DEPTH_OCC = (CW+1)'(DEPTH);

  a_no_grant_on_redirect: assert property (@(posedge clk) disable iff (!rst_n)
    !(redirect_i && mem_req_o && mem_gnt_i));
  a_occupancy_bounded: assert property (@(posedge clk) disable iff (!rst_n)
    ({1'b0, count} + {1'b0, outstanding}) <= DEPTH_OCC);
  a_rvalid_has_request: assert property (@(posedge clk) disable iff (!rst_n)
    !(mem_rvalid_i && (outstanding == {CW{1'b0}})));
  a_addr_aligned: assert property (@(posedge clk) disable iff (!rst_n)
    mem_addr_lo == 2'b00);
endmodule

module if_prefetch_stage #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  output logic                       mem_req_o,
  output logic [ADDR_WIDTH-1:0]      mem_addr_o,
  input  logic                       mem_gnt_i,
  input  logic                       mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]      mem_rdata_i,
  output logic                       instr_valid_o,
  output logic [DATA_WIDTH-1:0]      instr_o,
  output logic [ADDR_WIDTH-1:0]      instr_pc_o,
  input  logic                       instr_ready_i,
  input  logic                       redirect_i,
  input  logic [ADDR_WIDTH-1:0]      redirect_pc_i,
  output logic [$clog2(DEPTH):0]     outstanding_o
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(ADDR_WIDTH'(3));
  localparam logic [ADDR_WIDTH-1:0] PC_STEP    = ADDR_WIDTH'(4);
  localparam logic [CW:0]           DEPTH_OCC  = (CW+1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [DATA_WIDTH-1:0] buf_data_q [DEPTH];
  logic [DATA_WIDTH-1:0] buf_data_d [DEPTH];
  logic [ADDR_WIDTH-1:0] buf_pc_q   [DEPTH];
  logic [ADDR_WIDTH-1:0] buf_pc_d   [DEPTH];
  logic [ADDR_WIDTH-1:0] pcq_q      [DEPTH];
  logic [ADDR_WIDTH-1:0] pcq_d      [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] pcq_rd_ptr_q, pcq_rd_ptr_d, pcq_wr_ptr_q, pcq_wr_ptr_d;
  logic [CW-1:0] count_q, count_d, outstanding_q, outstanding_d;
  logic [CW-1:0] discard_q, discard_d;

  logic [CW:0] occupancy_s;
  logic        req_s, grant_s, drop_s, push_s, pop_s, valid_s;

  // Request gating, handshakes and response classification.
  always_comb begin
    occupancy_s = {1'b0, count_q} + {1'b0, outstanding_q};
    // rst_n gates the request so it is low for the whole reset interval.
    req_s   = rst_n && !redirect_i && (occupancy_s < DEPTH_OCC);
    grant_s = req_s && mem_gnt_i;
    valid_s = (count_q != {CW{1'b0}});
    drop_s  = (discard_q != {CW{1'b0}});
    // A response landing in the redirect cycle is stale by definition.
    push_s  = mem_rvalid_i && !drop_s && !redirect_i;
    pop_s   = valid_s && instr_ready_i && !redirect_i;
  end

  // Next-state computation for fetch PC, PC queue, buffer and counters.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    buf_data_d    = buf_data_q;
    buf_pc_d      = buf_pc_q;
    pcq_d         = pcq_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    pcq_rd_ptr_d  = pcq_rd_ptr_q;
    pcq_wr_ptr_d  = pcq_wr_ptr_q;
    count_d       = count_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;

    // PC queue tracks every in-flight request, discarded or not.
    if (grant_s) begin
      pcq_d[pcq_wr_ptr_q] = fetch_pc_q;
      pcq_wr_ptr_d        = pcq_wr_ptr_q + PW'(1);
    end else begin
      pcq_wr_ptr_d = pcq_wr_ptr_q;
    end
    if (mem_rvalid_i) begin
      pcq_rd_ptr_d = pcq_rd_ptr_q + PW'(1);
    end else begin
      pcq_rd_ptr_d = pcq_rd_ptr_q;
    end

    case ({grant_s, mem_rvalid_i})
      2'b10:   outstanding_d = outstanding_q + CW'(1);
      2'b01:   outstanding_d = outstanding_q - CW'(1);
      default: outstanding_d = outstanding_q;
    endcase

    if (redirect_i) begin
      fetch_pc_d = redirect_pc_i & ALIGN_MASK;
      rd_ptr_d   = {PW{1'b0}};
      wr_ptr_d   = {PW{1'b0}};
      count_d    = {CW{1'b0}};
      // Everything still in flight after this edge is stale.
      discard_d  = outstanding_q - (mem_rvalid_i ? CW'(1) : CW'(0));
    end else begin
      if (grant_s) begin
        fetch_pc_d = fetch_pc_q + PC_STEP;
      end else begin
        fetch_pc_d = fetch_pc_q;
      end
      if (mem_rvalid_i && drop_s) begin
        discard_d = discard_q - CW'(1);
      end else begin
        discard_d = discard_q;
      end
      if (push_s) begin
        buf_data_d[wr_ptr_q] = mem_rdata_i;
        buf_pc_d[wr_ptr_q]   = pcq_q[pcq_rd_ptr_q];
        wr_ptr_d             = wr_ptr_q + PW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q    <= RESET_PC & ALIGN_MASK;
      rd_ptr_q      <= {PW{1'b0}};
      wr_ptr_q      <= {PW{1'b0}};
      pcq_rd_ptr_q  <= {PW{1'b0}};
      pcq_wr_ptr_q  <= {PW{1'b0}};
      count_q       <= {CW{1'b0}};
      outstanding_q <= {CW{1'b0}};
      discard_q     <= {CW{1'b0}};
      for (int i = 0; i < int'(DEPTH); i++) begin
        buf_data_q[i] <= {DATA_WIDTH{1'b0}};
        buf_pc_q[i]   <= {ADDR_WIDTH{1'b0}};
        pcq_q[i]      <= {ADDR_WIDTH{1'b0}};
      end
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      pcq_rd_ptr_q  <= pcq_rd_ptr_d;
      pcq_wr_ptr_q  <= pcq_wr_ptr_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      buf_data_q    <= buf_data_d;
      buf_pc_q      <= buf_pc_d;
      pcq_q         <= pcq_d;
    end
  end

  // Output drive; head data is zeroed while the buffer is empty.
  always_comb begin
    mem_req_o     = req_s;
    mem_addr_o    = fetch_pc_q & ALIGN_MASK;
    instr_valid_o = valid_s;
    outstanding_o = outstanding_q;
    if (valid_s) begin
      instr_o    = buf_data_q[rd_ptr_q];
      instr_pc_o = buf_pc_q[rd_ptr_q];
    end else begin
      instr_o    = {DATA_WIDTH{1'b0}};
      instr_pc_o = {ADDR_WIDTH{1'b0}};
    end
  end

  if_prefetch_stage_chk #(.DEPTH(DEPTH), .CW(CW)) u_chk (
    .clk          (clk),
    .rst_n        (rst_n),
    .redirect_i   (redirect_i),
    .mem_req_o    (req_s),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_addr_lo  (mem_addr_o[1:0]),
    .count        (count_q),
    .outstanding  (outstanding_q)
  );
endmodule

// File: tb/tb_if_prefetch_stage.sv
// Directed bench for if_prefetch_stage with an in-order memory model.
module tb_if_prefetch_stage;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          mem_req_o;
  logic [AW-1:0] mem_addr_o;
  logic          mem_gnt_i;
  logic          mem_rvalid_i;
  logic [DW-1:0] mem_rdata_i;
  logic          instr_valid_o;
  logic [DW-1:0] instr_o;
  logic [AW-1:0] instr_pc_o;
  logic          instr_ready_i;
  logic          redirect_i;
  logic [AW-1:0] redirect_pc_i;
  logic [$clog2(D):0] outstanding_o;

  int n_total = 0;
  int n_bad   = 0;
  logic [AW-1:0] pend[$];
  bit            auto_rsp;
  logic [AW-1:0] exp_pc;
  int            grants;

  if_prefetch_stage #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(D),
                      .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .instr_valid_o(instr_valid_o), .instr_o(instr_o), .instr_pc_o(instr_pc_o),
    .instr_ready_i(instr_ready_i), .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i), .outstanding_o(outstanding_o)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] word_of(input logic [AW-1:0] a);
    return a ^ 32'hA5C3_0000;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive memory response, check any pop, track grants.
  task automatic tick();
    logic g, r;
    logic [AW-1:0] a;
    if (auto_rsp && pend.size() > 0) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = word_of(pend[0]);
    end else begin
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = 32'h0;
    end
    #1;
    if (instr_valid_o && instr_ready_i && !redirect_i) begin
      check_eq("pop_pc", instr_pc_o, exp_pc);
      check_eq("pop_data", instr_o, word_of(exp_pc));
      exp_pc = exp_pc + 32'd4;
    end
    g = mem_req_o && mem_gnt_i;
    r = mem_rvalid_i;
    a = mem_addr_o;
    @(posedge clk);
    if (r && pend.size() > 0) void'(pend.pop_front());
    if (g) begin
      pend.push_back(a);
      grants++;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0; mem_gnt_i = 1'b0;
    instr_ready_i = 1'b0; auto_rsp = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
    pend.delete();
    @(negedge clk); #1;
    check_eq("rst_req", mem_req_o, 1'b0);
    check_eq("rst_valid", instr_valid_o, 1'b0);
    check_eq("rst_instr", instr_o, 32'h0);
    check_eq("rst_pc", instr_pc_o, 32'h0);
    check_eq("rst_outst", outstanding_o, 3'd0);
    @(negedge clk);
    rst_n = 1'b1; grants = 0;
    #1;
    check_eq("post_rst_req", mem_req_o, 1'b1);
    check_eq("post_rst_addr", mem_addr_o, 32'h0);
  endtask

  // Redirect to 0x10 from idle and let two requests (0x10, 0x14) go out.
  task automatic two_in_flight();
    instr_ready_i = 1'b1;
    redirect_i = 1'b1; redirect_pc_i = 32'h10; #1;
    check_eq("req_in_redirect", mem_req_o, 1'b0);
    tick();
    redirect_i = 1'b0; mem_gnt_i = 1'b1; #1;
    check_eq("addr_after_redir", mem_addr_o, 32'h10);
    tick(); tick();
    mem_gnt_i = 1'b0; #1;
    check_eq("two_outst", outstanding_o, 3'd2);
    check_eq("addr_0x18", mem_addr_o, 32'h18);
  endtask

  initial begin
    rst_n = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0; mem_gnt_i = 1'b0;
    instr_ready_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
    auto_rsp = 1'b0; exp_pc = 32'h0; grants = 0;

    // Streaming: sequential addresses, head PCs 0,4,8...
    do_reset();
    mem_gnt_i = 1'b1; instr_ready_i = 1'b1; auto_rsp = 1'b1; exp_pc = 32'h0;
    for (int i = 0; i < 10; i++) begin
      #1;
      check_eq("stream_req", mem_req_o, 1'b1);
      check_eq("stream_addr", mem_addr_o, 32'(4 * i));
      tick();
    end
    check_eq("stream_pops", exp_pc, 32'h20);

    // Consumer stalled: exactly four requests, then one per pop.
    do_reset();
    mem_gnt_i = 1'b1; instr_ready_i = 1'b0; auto_rsp = 1'b1; exp_pc = 32'h0;
    repeat (8) tick();
    check_eq("full_grants", grants, 4);
    check_eq("full_req", mem_req_o, 1'b0);
    check_eq("full_outst", outstanding_o, 3'd0);
    check_eq("full_valid", instr_valid_o, 1'b1);
    check_eq("full_head", instr_pc_o, 32'h0);
    instr_ready_i = 1'b1;
    tick();
    instr_ready_i = 1'b0; #1;
    check_eq("refill_req", mem_req_o, 1'b1);
    check_eq("refill_addr", mem_addr_o, 32'h10);
    tick(); tick(); tick();
    check_eq("refill_grants", grants, 5);
    check_eq("refill_req_off", mem_req_o, 1'b0);
    check_eq("refill_head", instr_pc_o, 32'h4);

    // Drain continuously from full: PCs contiguous across pointer wrap.
    instr_ready_i = 1'b1;
    repeat (20) tick();
    check_eq("wrap_pops", exp_pc, 32'h54);
    check_eq("wrap_valid", instr_valid_o, 1'b1);

    // Grant withheld: request and address held steady.
    do_reset();
    mem_gnt_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check_eq("hold_req", mem_req_o, 1'b1);
      check_eq("hold_addr", mem_addr_o, 32'h0);
      check_eq("hold_outst", outstanding_o, 3'd0);
      tick();
    end
    mem_gnt_i = 1'b1;
    tick();
    check_eq("hold_release_outst", outstanding_o, 3'd1);
    check_eq("hold_release_addr", mem_addr_o, 32'h4);

    // Redirect with two stale requests in flight.
    do_reset();
    two_in_flight();
    redirect_i = 1'b1; redirect_pc_i = 32'h103; exp_pc = 32'h100;
    tick();
    redirect_i = 1'b0; #1;
    check_eq("redir_addr", mem_addr_o, 32'h100);
    check_eq("redir_outst", outstanding_o, 3'd2);
    mem_gnt_i = 1'b1; auto_rsp = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check_eq("redir_valid_low", instr_valid_o, 1'b0);
      tick();
    end
    check_eq("redir_valid", instr_valid_o, 1'b1);
    check_eq("redir_first_pc", instr_pc_o, 32'h100);
    tick();
    check_eq("redir_popped", exp_pc, 32'h104);

    // Redirect coincident with the 0x10 response: only 0x14 dropped.
    do_reset();
    two_in_flight();
    redirect_i = 1'b1; redirect_pc_i = 32'h200; auto_rsp = 1'b1; exp_pc = 32'h200;
    tick();
    redirect_i = 1'b0; mem_gnt_i = 1'b1; #1;
    check_eq("coinc_outst", outstanding_o, 3'd1);
    for (int k = 0; k < 2; k++) begin
      check_eq("coinc_valid_low", instr_valid_o, 1'b0);
      tick();
    end
    check_eq("coinc_valid", instr_valid_o, 1'b1);
    check_eq("coinc_first_pc", instr_pc_o, 32'h200);
    tick();
    check_eq("coinc_popped", exp_pc, 32'h204);

    // Reset mid-operation with requests in flight.
    mem_gnt_i = 1'b1; auto_rsp = 1'b0; instr_ready_i = 1'b0;
    tick(); tick();
    do_reset();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
